// File: rtl/mob_scheduler.sv
// Mob-map write scheduler: one map op per clock chosen from the periodic animation scan,
// shot kills, sight wakes and spawn probes. Owns the tick timer, spawn cap and score.
module mob_scheduler #(
    parameter int unsigned TICK_PERIOD  = 30000000,
    parameter int unsigned CELLS        = 256,
    parameter logic [7:0]  SPAWN_STRIDE = 8'd73,
    parameter logic [3:0]  BASE_MOBS    = 4'd3,
    parameter logic [3:0]  MAX_MOBS     = 4'd7
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       alive,
    input  logic       shoot_req,
    input  logic [7:0] shoot_idx,
    input  logic       seen_req,
    input  logic [7:0] seen_idx,
    input  logic       kill_hit,
    input  logic       spawn_free,
    output logic [7:0] chk_idx,
    output logic [7:0] spawn_idx,
    output logic       op_valid,
    output logic [2:0] op_code,
    output logic [7:0] op_idx,
    output logic       scanning,
    output logic [3:0] mob_cnt,
    output logic [3:0] mob_cap,
    output logic [6:0] score
);

    localparam int unsigned    TW        = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_PERIOD - 1);
    localparam logic [7:0]     SCAN_LAST = 8'(CELLS - 1);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_STEP  = 3'd1;
    localparam logic [2:0] OP_KILL  = 3'd2;
    localparam logic [2:0] OP_WAKE  = 3'd3;
    localparam logic [2:0] OP_SPAWN = 3'd4;

    typedef enum logic [1:0] {IDLE, RUN, SCAN} state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [7:0]    scan_idx;
    logic          pend_valid;
    logic [7:0]    pend_idx;

    logic          kill_fire;
    logic          wake_fire;
    logic          spawn_fire;
    logic [4:0]    cap_sum;
    logic [6:0]    score_inc;

    // A shot caught during the scan is parked here and served ahead of any fresh shot.
    assign chk_idx  = pend_valid ? pend_idx : shoot_idx;
    assign scanning = (state == SCAN);

    assign kill_fire  = (pend_valid | shoot_req) & kill_hit;
    assign wake_fire  = ~kill_fire & seen_req;
    assign spawn_fire = ~kill_fire & ~seen_req & spawn_free & (mob_cnt < mob_cap);
    assign score_inc  = (score >= 7'd99) ? 7'd99 : score + 7'd1;

    always_comb begin
        cap_sum = {1'b0, BASE_MOBS} + {2'b00, score[6:4]};
        mob_cap = (cap_sum > {1'b0, MAX_MOBS}) ? MAX_MOBS : cap_sum[3:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            scan_idx   <= '0;
            spawn_idx  <= '0;
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            op_valid   <= 1'b0;
            op_code    <= OP_NONE;
            op_idx     <= '0;
            mob_cnt    <= '0;
            score      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    op_valid <= 1'b0;
                    op_code  <= OP_NONE;
                    if (alive) state <= RUN;
                end
                RUN: begin
                    if (!alive) begin
                        state      <= IDLE;
                        scan_idx   <= '0;
                        pend_valid <= 1'b0;
                        op_valid   <= 1'b0;
                        op_code    <= OP_NONE;
                    end else begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            scan_idx <= '0;
                            state    <= SCAN;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                        // Any parked shot gets exactly one chance, hit or miss.
                        pend_valid <= 1'b0;
                        if (!wake_fire) spawn_idx <= spawn_idx + SPAWN_STRIDE;
                        if (kill_fire) begin
                            op_valid <= 1'b1;
                            op_code  <= OP_KILL;
                            op_idx   <= chk_idx;
                            mob_cnt  <= (mob_cnt != 4'd0) ? mob_cnt - 4'd1 : 4'd0;
                            score    <= score_inc;
                        end else if (wake_fire) begin
                            op_valid <= 1'b1;
                            op_code  <= OP_WAKE;
                            op_idx   <= seen_idx;
                        end else if (spawn_fire) begin
                            op_valid <= 1'b1;
                            op_code  <= OP_SPAWN;
                            op_idx   <= spawn_idx;
                            mob_cnt  <= mob_cnt + 4'd1;
                        end else begin
                            op_valid <= 1'b0;
                            op_code  <= OP_NONE;
                        end
                    end
                end
                SCAN: begin
                    if (!alive) begin
                        state      <= IDLE;
                        scan_idx   <= '0;
                        pend_valid <= 1'b0;
                        op_valid   <= 1'b0;
                        op_code    <= OP_NONE;
                    end else begin
                        op_valid <= 1'b1;
                        op_code  <= OP_STEP;
                        op_idx   <= scan_idx;
                        scan_idx <= scan_idx + 8'd1;
                        if (scan_idx == SCAN_LAST) state <= RUN;
                        if (shoot_req && !pend_valid) begin
                            pend_valid <= 1'b1;
                            pend_idx   <= shoot_idx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mob_scheduler.sv
// Directed bench for mob_scheduler: a frame-position reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_mob_scheduler;

    localparam int T     = 16;
    localparam int CELLS = 256;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       alive = 1'b0;
    logic       shoot_req = 1'b0;
    logic [7:0] shoot_idx = 8'h00;
    logic       seen_req = 1'b0;
    logic [7:0] seen_idx = 8'h00;
    logic       kill_hit = 1'b0;
    logic       spawn_free = 1'b0;
    logic [7:0] chk_idx;
    logic [7:0] spawn_idx;
    logic       op_valid;
    logic [2:0] op_code;
    logic [7:0] op_idx;
    logic       scanning;
    logic [3:0] mob_cnt;
    logic [3:0] mob_cap;
    logic [6:0] score;

    mob_scheduler #(.TICK_PERIOD(T), .CELLS(CELLS)) dut (
        .Clk(Clk), .Reset(Reset), .alive(alive),
        .shoot_req(shoot_req), .shoot_idx(shoot_idx),
        .seen_req(seen_req), .seen_idx(seen_idx),
        .kill_hit(kill_hit), .spawn_free(spawn_free),
        .chk_idx(chk_idx), .spawn_idx(spawn_idx),
        .op_valid(op_valid), .op_code(op_code), .op_idx(op_idx),
        .scanning(scanning), .mob_cnt(mob_cnt), .mob_cap(mob_cap), .score(score)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cap_of(input int s);
        int c;
        c = 3 + s / 16;
        return (c > 7) ? 7 : c;
    endfunction

    // Reference model: the game is a repeating frame of T run cycles then CELLS scan cycles;
    // m_pos is the position inside that frame.
    bit         started = 1'b0;
    bit         m_idle, m_pend, e_valid;
    int         m_pos, m_cnt, m_score, e_code;
    logic [7:0] m_spawn, m_pidx, e_idx;

    always @(posedge Clk) begin
        started = 1'b1;
        if (Reset) begin
            m_idle = 1; m_pos = 0; m_pend = 0; m_pidx = 0; m_spawn = 0;
            m_cnt = 0; m_score = 0; e_valid = 0; e_code = 0; e_idx = 0;
        end else if (m_idle) begin
            e_valid = 0; e_code = 0;
            if (alive) m_idle = 0;
        end else if (!alive) begin
            m_idle = 1; e_valid = 0; e_code = 0; m_pend = 0;
            if (m_pos >= T) m_pos = 0;
        end else if (m_pos >= T) begin
            e_valid = 1; e_code = 1; e_idx = 8'(m_pos - T);
            if (shoot_req && !m_pend) begin m_pend = 1; m_pidx = shoot_idx; end
            m_pos++;
            if (m_pos == T + CELLS) m_pos = 0;
        end else begin
            if ((m_pend || shoot_req) && kill_hit) begin
                e_valid = 1; e_code = 2; e_idx = m_pend ? m_pidx : shoot_idx;
                if (m_cnt > 0) m_cnt--;
                if (m_score < 99) m_score++;
            end else if (seen_req) begin
                e_valid = 1; e_code = 3; e_idx = seen_idx;
            end else if (spawn_free && m_cnt < cap_of(m_score)) begin
                e_valid = 1; e_code = 4; e_idx = m_spawn; m_cnt++;
            end else begin
                e_valid = 0; e_code = 0;
            end
            if (!seen_req || ((m_pend || shoot_req) && kill_hit)) m_spawn = m_spawn + 8'd73;
            m_pend = 0;
            m_pos++;
        end
    end

    int kill20 = 0;
    always @(negedge Clk) begin
        if (started) begin
            chk("op_valid", op_valid, e_valid);
            chk("op_code", op_code, e_code);
            if (e_valid) chk("op_idx", op_idx, e_idx);
            chk("scanning", scanning, (!m_idle && m_pos >= T));
            chk("mob_cnt", mob_cnt, m_cnt);
            chk("mob_cap", mob_cap, cap_of(m_score));
            chk("score", score, m_score);
            chk("spawn_idx", spawn_idx, m_spawn);
            chk("chk_idx", chk_idx, m_pend ? m_pidx : shoot_idx);
            if (op_valid && op_code == 3'd2 && op_idx == 8'h20) kill20++;
        end
    end

    task automatic cyc();
        @(posedge Clk); #1;
    endtask

    task automatic wait_scan_start();
        int n;
        n = 0;
        while (scanning !== 1'b1 && n < 400) begin cyc(); n++; end
        if (n >= 400) chk("wait_scan_start_timeout", 0, 1);
    endtask

    task automatic wait_scan_end();
        int n;
        wait_scan_start();
        n = 0;
        while (scanning !== 1'b0 && n < 400) begin cyc(); n++; end
        if (n >= 400) chk("wait_scan_end_timeout", 0, 1);
    endtask

    initial begin
        int first_step, step_cnt, nxt, n;
        bit contig, s63, s64, done;
        logic [7:0] sp[$];

        first_step = 0; step_cnt = 0; nxt = 0; contig = 1;
        s63 = 0; s64 = 0; done = 0;

        // Reset state
        repeat (3) cyc();
        chk("rst_op_valid", op_valid, 0);
        chk("rst_score", score, 0);
        chk("rst_mob_cnt", mob_cnt, 0);
        chk("rst_cap", mob_cap, 3);
        chk("rst_spawn_idx", spawn_idx, 0);

        // Start the game with every cell free: three spawns, then the first scan
        Reset = 0; alive = 1; spawn_free = 1;
        cyc();
        for (int k = 1; k <= 288; k++) begin
            cyc();
            if (op_valid && op_code == 3'd4) sp.push_back(op_idx);
            if (op_valid && op_code == 3'd1) begin
                if (first_step == 0) first_step = k;
                if (op_idx != 8'(nxt)) contig = 0;
                nxt++;
                step_cnt++;
            end
        end
        chk("first_step_cycle", first_step, 17);
        chk("step_count", step_cnt, 256);
        chk("step_contiguous", contig, 1);
        chk("spawn_count", sp.size(), 3);
        if (sp.size() == 3) begin
            chk("spawn0", sp[0], 8'd0);
            chk("spawn1", sp[1], 8'd73);
            chk("spawn2", sp[2], 8'd146);
        end
        chk("mob_cnt_after_spawn", mob_cnt, 3);
        cyc();
        chk("second_scan_code", op_code, 1);
        chk("second_scan_idx", op_idx, 0);

        // Shot and sight in the same cycle: kill first, wake next
        wait_scan_end();
        shoot_req = 1; shoot_idx = 8'h2A; kill_hit = 1; seen_req = 1; seen_idx = 8'h55;
        cyc();
        shoot_req = 0; kill_hit = 0;
        chk("kill_code", op_code, 2);
        chk("kill_idx", op_idx, 8'h2A);
        chk("kill_score", score, 1);
        chk("kill_mob_cnt", mob_cnt, 2);
        cyc();
        seen_req = 0;
        chk("wake_code", op_code, 3);
        chk("wake_idx", op_idx, 8'h55);

        // Shots during a scan: first is parked, second dropped
        wait_scan_start();
        repeat (40) cyc();
        shoot_req = 1; shoot_idx = 8'h10; cyc();
        shoot_req = 0; shoot_idx = 8'h33;
        chk("pend_chk_idx", chk_idx, 8'h10);
        repeat (30) cyc();
        shoot_req = 1; shoot_idx = 8'h20; cyc();
        shoot_req = 0; shoot_idx = 8'h00;
        chk("pend_keeps_first", chk_idx, 8'h10);
        kill_hit = 1;
        wait_scan_end();
        cyc();
        kill_hit = 0;
        chk("pend_kill_code", op_code, 2);
        chk("pend_kill_idx", op_idx, 8'h10);

        // Brief loss of alive in RUN and in SCAN
        repeat (3) cyc();
        alive = 0; repeat (3) cyc(); alive = 1;
        wait_scan_start();
        repeat (5) cyc();
        alive = 0; repeat (3) cyc(); alive = 1;
        chk("idle_no_op", op_valid, 0);

        // Kill stream up to score 98, watching the cap steps
        shoot_req = 1; shoot_idx = 8'h77; kill_hit = 1;
        n = 0;
        while (!done && n < 4000) begin
            cyc(); n++;
            if (score == 7'd63 && !s63) begin s63 = 1; chk("cap_at_63", mob_cap, 6); end
            if (score == 7'd64 && !s64) begin s64 = 1; chk("cap_at_64", mob_cap, 7); end
            if (score == 7'd98) done = 1;
        end
        shoot_req = 0; kill_hit = 0;
        chk("score_reached_98", done, 1);
        chk("cap_points_seen", s63 & s64, 1);

        // Two kills at 98: saturate at 99
        wait_scan_end();
        shoot_req = 1; kill_hit = 1; cyc();
        shoot_req = 0; kill_hit = 0;
        chk("score_99", score, 99);
        cyc();
        shoot_req = 1; kill_hit = 1; cyc();
        shoot_req = 0; kill_hit = 0;
        chk("sat_kill_code", op_code, 2);
        chk("score_stays_99", score, 99);
        chk("cap_max", mob_cap, 7);
        chk("no_kill_20", kill20, 0);

        // Reset in the middle of a scan
        wait_scan_start();
        n = 0;
        while (!(op_code == 3'd1 && op_idx == 8'd99) && n < 300) begin cyc(); n++; end
        chk("reached_scan_99", n < 300, 1);
        Reset = 1; cyc();
        chk("mid_rst_op_valid", op_valid, 0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_mob_cnt", mob_cnt, 0);
        chk("mid_rst_spawn_idx", spawn_idx, 0);
        chk("mid_rst_scanning", scanning, 0);
        Reset = 0;
        cyc();
        cyc();
        chk("restart_code", op_code, 4);
        chk("restart_idx", op_idx, 0);
        repeat (5) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
